// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: datapath widths, ALU opcode encoding and
// the ID/EX stage-register payload.
package dlx_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned OP_W    = 4;

  // r0 is hard-wired zero and is never a forwarding target
  localparam logic [RADDR_W-1:0] REG_ZERO = RADDR_W'(0);

  // ALU opcodes; 1011-1111 are reserved and carried through untouched
  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADDU = 4'b0010;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SUBU = 4'b0111;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b1000;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b1010;

  // ID/EX stage register; an all-zero value is a clean bubble
  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;
    logic [XLEN-1:0]    imm;
    logic               use_imm;
    logic [OP_W-1:0]    alu_op;
    logic [RADDR_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// Ports: idx/reg_val = latched source index and regfile value;
//        exmem_* / memwb_* = forwarding sources; val_c = selected operand.
module fwd_mux
  import dlx_pkg::*;
(
  input  logic [RADDR_W-1:0] idx,
  input  logic [XLEN-1:0]    reg_val,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic               exmem_reg_write,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic               memwb_reg_write,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    val_c
);

  // Youngest producer wins; r0 always reads the register file
  always_comb begin
    val_c = reg_val;
    if (idx == REG_ZERO) begin
      val_c = reg_val;
    end else if (exmem_reg_write && (exmem_rd == idx)) begin
      val_c = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == idx)) begin
      val_c = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use
// hazard detection. Drives the ALU operands (A, B, Op) and the EX/MEM
// control bundle.
// Ports: id_* = decoded instruction from ID; exmem_* / memwb_* = forwarding
//        sources; flush = kill instruction entering EX; hold = global freeze;
//        A/B/Op = ALU inputs; ex_* = stage outputs to EX/MEM;
//        stall_id = freeze PC and IF/ID (load-use).
module id_ex_operand_stage
  import dlx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic               id_rs2_used,
  input  logic [XLEN-1:0]    id_rs1_val,
  input  logic [XLEN-1:0]    id_rs2_val,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_use_imm,
  input  logic [OP_W-1:0]    id_alu_op,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic               exmem_reg_write,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic               memwb_reg_write,
  input  logic [XLEN-1:0]    memwb_result,
  input  logic               flush,
  input  logic               hold,
  output logic [XLEN-1:0]    A,
  output logic [XLEN-1:0]    B,
  output logic [OP_W-1:0]    Op,
  output logic               ex_valid,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [XLEN-1:0]    ex_store_data,
  output logic               stall_id
);

  id_ex_t          stage_q;
  id_ex_t          stage_nxt;
  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    stall_id = 1'b0;
    if (!hold && id_valid && stage_q.valid && stage_q.mem_read &&
        (stage_q.rd != REG_ZERO) &&
        ((stage_q.rd == id_rs1) || (id_rs2_used && (stage_q.rd == id_rs2)))) begin
      stall_id = 1'b1;
    end
  end

  // Next stage contents: hold > flush > load-use bubble > capture
  always_comb begin
    stage_nxt = stage_q;
    if (hold) begin
      stage_nxt = stage_q;
    end else if (flush || stall_id || !id_valid) begin
      stage_nxt = '0;
    end else begin
      stage_nxt.valid     = 1'b1;
      stage_nxt.rs1       = id_rs1;
      stage_nxt.rs2       = id_rs2;
      stage_nxt.rs1_val   = id_rs1_val;
      stage_nxt.rs2_val   = id_rs2_val;
      stage_nxt.imm       = id_imm;
      stage_nxt.use_imm   = id_use_imm;
      stage_nxt.alu_op    = id_alu_op;
      stage_nxt.rd        = id_rd;
      stage_nxt.reg_write = id_reg_write;
      stage_nxt.mem_read  = id_mem_read;
      stage_nxt.mem_write = id_mem_write;
    end
  end

  // Stage register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_nxt;
    end
  end

  fwd_mux u_fwd_rs1 (
    .idx             (stage_q.rs1),
    .reg_val         (stage_q.rs1_val),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .val_c           (rs1_fwd_c)
  );

  fwd_mux u_fwd_rs2 (
    .idx             (stage_q.rs2),
    .reg_val         (stage_q.rs2_val),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .val_c           (rs2_fwd_c)
  );

  // ALU operands and EX/MEM bundle
  assign A             = rs1_fwd_c;
  assign B             = stage_q.use_imm ? stage_q.imm : rs2_fwd_c;
  assign Op            = stage_q.alu_op;
  assign ex_store_data = rs2_fwd_c;
  assign ex_valid      = stage_q.valid;
  assign ex_rd         = stage_q.rd;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, checked against an instruction-level reference model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs2_used;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm;
  logic        id_use_imm;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        flush, hold;
  logic [31:0] A, B;
  logic [3:0]  Op;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_store_data;
  logic        stall_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs2_used(id_rs2_used), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .flush(flush), .hold(hold), .A(A), .B(B), .Op(Op), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .stall_id(stall_id)
  );

  // Instruction currently sitting in EX, as the reference model sees it
  typedef struct {
    bit        live;
    bit [4:0]  src1, src2, dest;
    bit [31:0] val1, val2, imm;
    bit        imm_b;
    bit [3:0]  op;
    bit        wr, ld, st;
  } instr_t;

  typedef struct {
    logic [31:0] a, b, store;
    logic [3:0]  op;
    logic        valid, rw, mr, mw, stall;
    logic [4:0]  rd;
  } exp_t;

  instr_t in_ex = '{default: 0};
  exp_t   sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2, 4'd3: return a + b;
      4'd4, 4'd7: return a - b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return a ^ b;
      4'd9:  return a << b[4:0];
      4'd10: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Most recent writer of a register among the in-flight older instructions
  function automatic logic [31:0] operand(input bit [4:0] r, input bit [31:0] rf);
    if (r == 0) return rf;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  function automatic logic load_use();
    if (hold || !id_valid || !in_ex.live || !in_ex.ld || in_ex.dest == 0) return 1'b0;
    return (in_ex.dest == id_rs1) || (id_rs2_used && in_ex.dest == id_rs2);
  endfunction

  // Advance the model across one rising edge, using the inputs applied this cycle
  task automatic step();
    logic st;
    @(posedge clk);
    st = load_use();
    if (!rst_n) in_ex = '{default: 0};
    else if (hold) in_ex = in_ex;
    else if (flush || st || !id_valid) in_ex = '{default: 0};
    else in_ex = '{live: 1, src1: id_rs1, src2: id_rs2, dest: id_rd, val1: id_rs1_val,
                   val2: id_rs2_val, imm: id_imm, imm_b: id_use_imm, op: id_alu_op,
                   wr: id_reg_write, ld: id_mem_read, st: id_mem_write};
    #1;
  endtask

  task automatic expect_now();
    exp_t e;
    e.a     = operand(in_ex.src1, in_ex.val1);
    e.store = operand(in_ex.src2, in_ex.val2);
    e.b     = in_ex.imm_b ? in_ex.imm : e.store;
    e.op    = in_ex.op;
    e.valid = in_ex.live;
    e.rd    = in_ex.dest;
    e.rw    = in_ex.wr;
    e.mr    = in_ex.ld;
    e.mw    = in_ex.st;
    e.stall = load_use();
    sb.push_back(e);
  endtask

  // Monitor: compare the stage outputs against the oldest pending expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("A", A, e.a);
      chk("B", B, e.b);
      chk("Op", 32'(Op), 32'(e.op));
      chk("store_data", ex_store_data, e.store);
      chk("ex_valid", 32'(ex_valid), 32'(e.valid));
      chk("ex_rd", 32'(ex_rd), 32'(e.rd));
      chk("ex_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'd0, e.rw, e.mr, e.mw});
      chk("stall_id", 32'(stall_id), 32'(e.stall));
    end
  end

  task automatic clr();
    rst_n = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rs1_val = 0; id_rs2_val = 0; id_imm = 0; id_use_imm = 0; id_alu_op = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0; flush = 0; hold = 0;
  endtask

  task automatic set_id(input bit [3:0] op, input bit [4:0] r1, input bit [31:0] v1,
                        input bit [4:0] r2, input bit [31:0] v2, input bit r2u,
                        input bit ui, input bit [31:0] im, input bit [4:0] rd,
                        input bit rw, input bit mr, input bit mw);
    id_valid = 1; id_alu_op = op; id_rs1 = r1; id_rs1_val = v1; id_rs2 = r2;
    id_rs2_val = v2; id_rs2_used = r2u; id_use_imm = ui; id_imm = im; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    clr();
    // Reset held for two edges with a live instruction in ID
    rst_n = 0;
    set_id(4'd2, 5'd1, 32'h11, 5'd2, 32'h22, 1, 0, 0, 5'd3, 1, 1, 0);
    step(); expect_now();
    step(); expect_now();
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_op", 32'(Op), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
    chk("rst_A", A, 32'd0);

    // Forwarding priority: EX/MEM beats MEM/WB
    step(); clr();
    set_id(4'd2, 5'd3, 32'h123, 5'd4, 32'hffff, 1, 0, 0, 5'd9, 1, 0, 0);
    expect_now();
    step(); clr();
    exmem_rd = 3; exmem_result = 32'h3f; exmem_reg_write = 1;
    memwb_rd = 3; memwb_result = 32'h1; memwb_reg_write = 1;
    expect_now();
    @(negedge clk);
    chk("prio_A", A, 32'h3f);
    chk("prio_B", B, 32'hffff);
    chk("prio_result", alu_ref(A, B, Op), 32'h1003e);

    // r0 is never forwarded
    step(); clr();
    set_id(4'd9, 5'd0, 32'h0, 5'd0, 32'h0, 0, 1, 32'd6, 5'd2, 1, 0, 0);
    expect_now();
    step(); clr();
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hdead;
    expect_now();
    @(negedge clk);
    chk("r0_A", A, 32'h0);
    step(); clr();
    set_id(4'd9, 5'd6, 32'h11, 5'd0, 32'h0, 0, 1, 32'd6, 5'd2, 1, 0, 0);
    expect_now();
    step(); clr();
    memwb_rd = 6; memwb_reg_write = 1; memwb_result = 32'haaaaaaaa;
    expect_now();
    @(negedge clk);
    chk("sll_result", alu_ref(A, B, Op), 32'haaaaaa80);

    // Load-use: one stall cycle, bubble, then SUB with memwb forwarding
    step(); clr();
    set_id(4'd2, 5'd1, 32'h100, 5'd0, 32'h0, 0, 1, 32'd4, 5'd5, 1, 1, 0);
    expect_now();
    step(); clr();
    set_id(4'd4, 5'd1, 32'h100, 5'd5, 32'h5555, 1, 0, 0, 5'd6, 1, 0, 0);
    expect_now();
    @(negedge clk);
    chk("lu_stall", 32'(stall_id), 32'd1);
    step(); expect_now();
    @(negedge clk);
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_stall", 32'(stall_id), 32'd0);
    step(); clr();
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h77;
    expect_now();
    @(negedge clk);
    chk("lu_sub_valid", 32'(ex_valid), 32'd1);
    chk("lu_sub_B", B, 32'h77);
    chk("lu_sub_result", alu_ref(A, B, Op), 32'h89);

    // Flush during load-use: stall still raised, bubble enters EX
    step(); clr();
    set_id(4'd2, 5'd1, 32'h100, 5'd0, 32'h0, 0, 1, 32'd4, 5'd5, 1, 1, 0);
    expect_now();
    step(); clr();
    set_id(4'd4, 5'd5, 32'h1, 5'd2, 32'h2, 1, 0, 0, 5'd6, 1, 0, 0);
    flush = 1;
    expect_now();
    @(negedge clk);
    chk("fl_stall", 32'(stall_id), 32'd1);
    step(); clr(); expect_now();
    @(negedge clk);
    chk("fl_valid", 32'(ex_valid), 32'd0);

    // Hold beats flush: stage contents frozen
    step(); clr();
    set_id(4'd8, 5'd2, 32'hf0f0, 5'd3, 32'h0ff0, 1, 0, 0, 5'd4, 1, 0, 0);
    expect_now();
    step(); clr();
    set_id(4'd1, 5'd8, 32'h1234, 5'd9, 32'h5678, 1, 0, 0, 5'd10, 1, 0, 0);
    hold = 1; flush = 1;
    expect_now();
    step(); expect_now();
    @(negedge clk);
    chk("hold_valid", 32'(ex_valid), 32'd1);
    chk("hold_op", 32'(Op), 32'd8);
    chk("hold_result", alu_ref(A, B, Op), 32'hff00);

    // Store: immediate on B, forwarded rs2 on store data
    step(); clr();
    set_id(4'd2, 5'd0, 32'h0, 5'd7, 32'h1234, 1, 1, 32'd8, 5'd0, 0, 0, 1);
    expect_now();
    step(); clr();
    exmem_rd = 7; exmem_reg_write = 1; exmem_result = 32'h80000001;
    expect_now();
    @(negedge clk);
    chk("sw_B", B, 32'd8);
    chk("sw_store", ex_store_data, 32'h80000001);
    chk("sw_mem_write", 32'(ex_mem_write), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst_n        = ($urandom_range(0, 99) != 0);
      id_valid     = ($urandom_range(0, 9) != 0);
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rs2_used  = 1'($urandom);
      id_rs1_val   = (id_rs1 == 0) ? 32'd0 : $urandom;
      id_rs2_val   = (id_rs2 == 0) ? 32'd0 : $urandom;
      id_imm       = $urandom;
      id_use_imm   = 1'($urandom);
      id_alu_op    = 4'($urandom);
      id_rd        = 5'($urandom_range(0, 7));
      id_reg_write = 1'($urandom);
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_reg_write = 1'($urandom);
      exmem_result    = $urandom;
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_reg_write = 1'($urandom);
      memwb_result    = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      expect_now();
    end

    step(); clr();
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
